// File: rtl/pulse_event_queue_pkg.sv
// Shared defaults and helpers for the pulse event queue.
// - DEF_DEPTH / DEF_TS_W / DEF_DROP_W : default parameter values
// - lvl_w()                           : width of an occupancy count for a given depth
// - occ_e                             : occupancy class derived from the level count
package pulse_event_queue_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DROP_W = 8;

    // Level must represent 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/evq_fifo_mem.sv
// Storage array for the event queue.
// - we/waddr/wdata : synchronous write port
// - raddr/rdata    : asynchronous read, gives first-word fall-through at the top level
// The array is intentionally not reset; validity is tracked by the level count.
module evq_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [TS_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [TS_W-1:0]          rdata
);

    logic [TS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pulse_event_queue.sv
// Timestamps single-cycle event pulses and queues the stamps for a
// valid/ready consumer. Pulses that find the queue full are counted.
// - clk, rst  : single clock, synchronous active-high reset
// - pulse_in  : 1-cycle event pulse
// - ev_valid / ev_ts / ev_ready : head-of-queue handshake (fall-through)
// - level     : entries currently held (0..DEPTH)
// - ovf       : sticky "some pulse was dropped"
// - drop_cnt  : saturating count of dropped pulses
// - clr_ovf   : clears ovf/drop_cnt (a same-cycle drop still registers)
module pulse_event_queue
    import pulse_event_queue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TS_W   = DEF_TS_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse_in,
    output logic                    ev_valid,
    output logic [TS_W-1:0]         ev_ts,
    input  logic                    ev_ready,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    ovf,
    output logic [DROP_W-1:0]       drop_cnt,
    input  logic                    clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [TS_W-1:0]  ts;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    occ_e             occ;
    logic             push, pop, drop;

    // Occupancy class and handshake decode.
    always_comb begin
        occ = OCC_PART;
        if (level == '0)                occ = OCC_EMPTY;
        else if (level == LVL_W'(DEPTH)) occ = OCC_FULL;

        ev_valid = (occ != OCC_EMPTY);
        pop      = ev_valid & ev_ready;
        // A pop in the same cycle frees the head slot, so a full queue
        // still accepts the new stamp.
        push     = pulse_in & ((occ != OCC_FULL) | pop);
        drop     = pulse_in & (occ == OCC_FULL) & ~pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Clear has priority, but a drop in the clearing cycle is still recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            ovf      <= drop;
            drop_cnt <= drop ? DROP_W'(1) : '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    evq_fifo_mem #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~rst),
        .waddr (wr_ptr),
        .wdata (ts),
        .raddr (rd_ptr),
        .rdata (ev_ts)
    );

endmodule

// File: tb/tb_pulse_event_queue.sv
// Self-checking bench for pulse_event_queue: directed scenarios followed by
// randomized traffic, checked by a queue-based reference model and a
// negedge monitor.
module tb_pulse_event_queue;

    localparam int DEPTH  = 4;
    localparam int TS_W   = 16;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pulse_in = 1'b0;
    logic              ev_ready = 1'b0;
    logic              clr_ovf  = 1'b0;
    logic              ev_valid;
    logic [TS_W-1:0]   ev_ts;
    logic [2:0]        level;
    logic              ovf;
    logic [DROP_W-1:0] drop_cnt;

    pulse_event_queue #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .ev_valid (ev_valid),
        .ev_ts    (ev_ts),
        .ev_ready (ev_ready),
        .level    (level),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: cycle counter, list of held stamps, drop bookkeeping.
    logic [TS_W-1:0] m_ts = '0;
    int              m_level = 0;
    bit              m_ovf = 0;
    int              m_drop = 0;
    bit              started = 0;
    logic [TS_W-1:0] exp_q[$];

    always @(posedge clk) begin
        bit do_pop, do_push, do_drop;
        if (rst) begin
            m_ts = '0; m_level = 0; m_ovf = 0; m_drop = 0;
            exp_q.delete();
            started = 1;
        end else begin
            do_pop  = (m_level > 0) && ev_ready;
            do_push = pulse_in && ((m_level < DEPTH) || do_pop);
            do_drop = pulse_in && !do_push;
            if (do_push) exp_q.push_back(m_ts);
            m_level += int'(do_push) - int'(do_pop);
            if (clr_ovf) begin
                m_ovf  = do_drop;
                m_drop = do_drop ? 1 : 0;
            end else if (do_drop) begin
                m_ovf = 1;
                if (m_drop < (1 << DROP_W) - 1) m_drop++;
            end
            m_ts = m_ts + 1'b1;
        end
    end

    // Monitor: compare DUT state to the model; consume the head on a handshake.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("mon_level", 32'(level), 32'(m_level));
            chk("mon_valid", 32'(ev_valid), 32'(m_level > 0));
            chk("mon_ovf", 32'(ovf), 32'(m_ovf));
            chk("mon_drop_cnt", 32'(drop_cnt), 32'(m_drop));
            if (ev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mon_ts: got %0d with empty scoreboard", ev_ts);
                end else begin
                    chk("mon_ts", 32'(ev_ts), 32'(exp_q[0]));
                    if (ev_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pulse_in = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic go_ts(input int t);
        int n = 0;
        while (m_ts != TS_W'(t) && n < 70000) begin
            cyc();
            n++;
        end
        if (m_ts != TS_W'(t)) begin
            n_checks++; n_fail++;
            $display("FAIL go_ts_timeout: got %0d expected %0d", m_ts, t);
        end
    endtask

    // Pulse held for n consecutive cycles starting at stamp t0.
    task automatic pulses(input int t0, input int n);
        go_ts(t0);
        pulse_in = 1'b1;
        repeat (n) cyc();
        pulse_in = 1'b0;
    endtask

    task automatic drain_expect(input string nm, input int v0, input int v1, input int v2, input int v3);
        int vals[4];
        vals = '{v0, v1, v2, v3};
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk(nm, 32'(ev_ts), 32'(vals[i]));
            cyc();
        end
        ev_ready = 1'b0;
        chk({nm, "_empty"}, 32'(ev_valid), 0);
    endtask

    initial begin
        cyc();
        do_reset();
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // Single pulse, then pop.
        pulses(5, 1);
        chk("single_valid", 32'(ev_valid), 1);
        chk("single_ts", 32'(ev_ts), 5);
        chk("single_level", 32'(level), 1);
        ev_ready = 1'b1; cyc(); ev_ready = 1'b0;
        chk("single_pop_valid", 32'(ev_valid), 0);
        chk("single_pop_level", 32'(level), 0);

        // Four spaced pulses, FIFO order.
        pulses(10, 1); pulses(12, 1); pulses(14, 1); pulses(16, 1);
        chk("four_level", 32'(level), 4);
        chk("four_ovf", 32'(ovf), 0);
        drain_expect("four_order", 10, 12, 14, 16);

        // Full plus three drops.
        do_reset();
        pulses(1, 7);
        chk("drop_level", 32'(level), 4);
        chk("drop_ovf", 32'(ovf), 1);
        chk("drop_cnt3", 32'(drop_cnt), 3);
        drain_expect("drop_contents", 1, 2, 3, 4);

        // Full with simultaneous push and pop.
        do_reset();
        pulses(1, 4);
        go_ts(20);
        pulse_in = 1'b1; ev_ready = 1'b1; cyc(); pulse_in = 1'b0; ev_ready = 1'b0;
        chk("pp_level", 32'(level), 4);
        chk("pp_ovf", 32'(ovf), 0);
        drain_expect("pp_order", 2, 3, 4, 20);

        // clr_ovf coinciding with a drop, then alone.
        do_reset();
        pulses(1, 6);
        chk("clr_pre_cnt", 32'(drop_cnt), 2);
        pulse_in = 1'b1; clr_ovf = 1'b1; cyc(); pulse_in = 1'b0; clr_ovf = 1'b0;
        chk("clr_drop_ovf", 32'(ovf), 1);
        chk("clr_drop_cnt", 32'(drop_cnt), 1);
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        chk("clr_alone_ovf", 32'(ovf), 0);
        chk("clr_alone_cnt", 32'(drop_cnt), 0);
        drain_expect("clr_contents", 1, 2, 3, 4);

        // Counter wrap, then reset with entries held.
        pulses(65535, 4);
        chk("wrap_head", 32'(ev_ts), 65535);
        ev_ready = 1'b1; cyc(); ev_ready = 1'b0;
        chk("wrap_next", 32'(ev_ts), 0);
        chk("wrap_level", 32'(level), 3);
        rst = 1'b1; pulse_in = 1'b1; cyc(); rst = 1'b0; pulse_in = 1'b0;
        chk("midrst_level", 32'(level), 0);
        chk("midrst_valid", 32'(ev_valid), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pulse_in = ($urandom_range(99) < 45);
            ev_ready = ($urandom_range(99) < 40);
            clr_ovf  = ($urandom_range(99) < 3);
            rst      = ($urandom_range(999) < 4);
            cyc();
        end
        rst = 1'b0; pulse_in = 1'b0; ev_ready = 1'b1; clr_ovf = 1'b0;
        repeat (8) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
